// File: rtl/registers.sv
// RV32I integer register file: 32 x 32-bit, x0 hardwired to zero, two
// combinational read ports, one synchronous write port fed by a write-back mux.

`ifndef REG_WB_ALU_OUT
`define REG_WB_ALU_OUT 2'b00
`endif
`ifndef REG_WB_IMM_DAT
`define REG_WB_IMM_DAT 2'b01
`endif
`ifndef REG_WB_MEM_DAT
`define REG_WB_MEM_DAT 2'b10
`endif
`ifndef REG_WB_PC_NEXT
`define REG_WB_PC_NEXT 2'b11
`endif

module registers #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ADDR_WIDTH-1:0] rs1,
  input  logic [ADDR_WIDTH-1:0] rs2,
  input  logic [ADDR_WIDTH-1:0] rd,
  input  logic                  we,
  input  logic [1:0]            wb_select,
  input  logic [DATA_WIDTH-1:0] alu_result,
  input  logic [DATA_WIDTH-1:0] imm_data,
  input  logic [DATA_WIDTH-1:0] mem_data,
  input  logic [DATA_WIDTH-1:0] pc_next,
  output logic [DATA_WIDTH-1:0] read_data1,
  output logic [DATA_WIDTH-1:0] read_data2
);

  localparam int NUM_REGS = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] wb_data;
  logic [DATA_WIDTH-1:0] rf [NUM_REGS];

  always_comb begin
    wb_data = alu_result;
    case (wb_select)
      `REG_WB_ALU_OUT: wb_data = alu_result;
      `REG_WB_IMM_DAT: wb_data = imm_data;
      `REG_WB_MEM_DAT: wb_data = mem_data;
      `REG_WB_PC_NEXT: wb_data = pc_next;
      default:         wb_data = alu_result;
    endcase
  end

  // x0 has no storage; every other entry is its own flop bank with a decoded enable.
  for (genvar i = 0; i < NUM_REGS; i++) begin : g_reg
    if (i == 0) begin : g_zero
      assign rf[i] = '0;
    end else begin : g_flop
      logic [DATA_WIDTH-1:0] q;
      logic                  wr_en;

      assign wr_en = we && (rd == ADDR_WIDTH'(i));

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          q <= '0;
        end else if (wr_en) begin
          q <= wb_data;
        end
      end

      assign rf[i] = q;
    end
  end

  // No write bypass: a same-cycle read of rd sees the old value until the edge.
  assign read_data1 = rf[rs1];
  assign read_data2 = rf[rs2];

endmodule

// File: tb/tb_registers.sv
// Directed self-checking bench for the register file with write-back mux.

module tb_registers;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [4:0]  rs1, rs2, rd;
  logic        we;
  logic [1:0]  wb_select;
  logic [31:0] alu_result, imm_data, mem_data, pc_next;
  logic [31:0] read_data1, read_data2;

  int total = 0;
  int bad   = 0;

  registers dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rs1        (rs1),
    .rs2        (rs2),
    .rd         (rd),
    .we         (we),
    .wb_select  (wb_select),
    .alu_result (alu_result),
    .imm_data   (imm_data),
    .mem_data   (mem_data),
    .pc_next    (pc_next),
    .read_data1 (read_data1),
    .read_data2 (read_data2)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  // Drives one write with distinct filler on the unselected sources, then
  // waits one edge and drops we.
  task automatic do_write(input logic [1:0] sel, input logic [4:0] idx, input logic [31:0] val);
    wb_select  = sel;
    rd         = idx;
    alu_result = 32'h0BAD_0000;
    imm_data   = 32'h0BAD_0001;
    mem_data   = 32'h0BAD_0002;
    pc_next    = 32'h0BAD_0003;
    case (sel)
      2'b00: alu_result = val;
      2'b01: imm_data   = val;
      2'b10: mem_data   = val;
      default: pc_next  = val;
    endcase
    we = 1'b1;
    @(posedge clk);
    #1;
    we = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    rs1 = 5'd5; rs2 = 5'd31; rd = 5'd3; we = 1'b0; wb_select = 2'b00;
    alu_result = 32'h0; imm_data = 32'h0; mem_data = 32'h0; pc_next = 32'h0;

    // Reset state, and a write attempted while reset is held is ignored.
    #2;
    check("reset_rd1", read_data1, 32'h0);
    check("reset_rd2", read_data2, 32'h0);
    rs1 = 5'd3; we = 1'b1; alu_result = 32'hDEAD_BEEF;
    @(posedge clk); #1;
    check("write_in_reset", read_data1, 32'h0);
    we = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // 1: ALU source into x1.
    do_write(2'b00, 5'd1, 32'hAAAA_AAAA);
    rs1 = 5'd1; #1;
    check("alu_x1", read_data1, 32'hAAAA_AAAA);

    // 2: IMM source into x2, with read-during-write before the edge.
    rs2 = 5'd2; wb_select = 2'b01; rd = 5'd2; imm_data = 32'h5555_5555;
    alu_result = 32'h0BAD_0000; mem_data = 32'h0BAD_0002; pc_next = 32'h0BAD_0003;
    we = 1'b1; #1;
    check("rdw_old", read_data2, 32'h0);
    @(posedge clk); #1;
    we = 1'b0;
    check("imm_x2", read_data2, 32'h5555_5555);
    check("x1_kept", read_data1, 32'hAAAA_AAAA);

    // 3: MEM source overwrites x1.
    do_write(2'b10, 5'd1, 32'hCCCC_CCCC);
    check("mem_x1", read_data1, 32'hCCCC_CCCC);

    // 4: PC+4 source into x4.
    do_write(2'b11, 5'd4, 32'h1234_5678);
    rs2 = 5'd4; #1;
    check("pc_x4", read_data2, 32'h1234_5678);

    // 5: writes to x0 are discarded.
    do_write(2'b00, 5'd0, 32'hFFFF_FFFF);
    rs1 = 5'd0; rs2 = 5'd0; #1;
    check("x0_rd1", read_data1, 32'h0);
    check("x0_rd2", read_data2, 32'h0);

    // Top index, both ports on the same register.
    do_write(2'b00, 5'd31, 32'h8000_0001);
    rs1 = 5'd31; rs2 = 5'd31; #1;
    check("x31_rd1", read_data1, 32'h8000_0001);
    check("x31_rd2", read_data2, 32'h8000_0001);

    // we=0 with changing sources leaves contents unchanged.
    rd = 5'd1; we = 1'b0;
    for (int i = 0; i < 4; i++) begin
      wb_select  = 2'(i);
      alu_result = 32'h1111_0000 + 32'(i);
      imm_data   = 32'h2222_0000 + 32'(i);
      mem_data   = 32'h3333_0000 + 32'(i);
      pc_next    = 32'h4444_0000 + 32'(i);
      @(posedge clk); #1;
    end
    rs1 = 5'd1; rs2 = 5'd2; #1;
    check("idle_x1", read_data1, 32'hCCCC_CCCC);
    check("idle_x2", read_data2, 32'h5555_5555);
    rs1 = 5'd3; #1;
    check("x3_untouched", read_data1, 32'h0);

    // Reset between edges clears everything at once and beats a pending write.
    rs1 = 5'd1; rs2 = 5'd4;
    rd = 5'd4; wb_select = 2'b00; alu_result = 32'h7777_7777; we = 1'b1;
    @(posedge clk); #2;
    rst_n = 1'b0; #1;
    check("async_clr_x1", read_data1, 32'h0);
    check("async_clr_x4", read_data2, 32'h0);
    @(posedge clk); #1;
    check("reset_beats_write", read_data2, 32'h0);
    we = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    rs1 = 5'd31; rs2 = 5'd2; #1;
    check("post_reset_x31", read_data1, 32'h0);
    check("post_reset_x2", read_data2, 32'h0);

    // Writes resume after reset.
    do_write(2'b01, 5'd2, 32'h0000_00A5);
    check("post_reset_write", read_data2, 32'h0000_00A5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/registers.md
Name: registers

Overview:
RV32I integer register file with an integrated write-back source multiplexer.
- 32 x 32-bit registers; x0 is hardwired to zero.
- Two asynchronous (combinational) read ports and one synchronous write port.
- The write data is selected from four datapath sources: ALU result, immediate, memory load data, and PC+4.
- Sits in the CPU core between decode/execute (read operands) and the write-back stage.

Parameters:
DATA_WIDTH  32  register and data-path width
ADDR_WIDTH  5   register index width (2**ADDR_WIDTH = 32 registers)

Ports:
clk         input   1   system clock; writes occur on the rising edge
rst_n       input   1   asynchronous active-low reset
rs1         input   5   read port 1 register index
rs2         input   5   read port 2 register index
rd          input   5   write register index
we          input   1   write enable, active high
wb_select   input   2   write-back source select (encodings below)
alu_result  input   32  write-back source: ALU output
imm_data    input   32  write-back source: immediate (e.g. LUI)
mem_data    input   32  write-back source: load data
pc_next     input   32  write-back source: PC+4 (JAL/JALR link)
read_data1  output  32  contents of register rs1
read_data2  output  32  contents of register rs2

Behaviour:
- wb_select encodings are shared through the project include as macros:
  - REG_WB_ALU_OUT = 2'b00 -> alu_result
  - REG_WB_IMM_DAT = 2'b01 -> imm_data
  - REG_WB_MEM_DAT = 2'b10 -> mem_data
  - REG_WB_PC_NEXT = 2'b11 -> pc_next
  - The mux is purely combinational and fully decoded; there is no illegal code.
- Reset:
  - While rst_n = 0, all 32 registers clear to 0 asynchronously.
  - read_data1 and read_data2 therefore read 0 during and right after reset.
  - Writes are ignored while rst_n = 0.
  - If reset is asserted mid-operation, it overrides any pending write in that cycle.
- Write:
  - On posedge clk with rst_n = 1, we = 1 and rd != 0, the register at rd is loaded with the mux output.
  - Write latency is one edge: the new value is visible on the read ports right after that edge.
- x0:
  - Writes to rd = 0 are discarded.
  - Reading index 0 on either port always returns 32'h0000_0000.
- Read:
  - read_data1 = reg[rs1] and read_data2 = reg[rs2], combinational with zero latency.
  - Both ports may address the same register simultaneously.
- Read-during-write:
  - There is no internal bypass.
  - A read of rd in the same cycle as its write returns the old value until the clock edge, then the new value.
  - Forwarding, if required, is the pipeline's responsibility.
- Unselected sources and inputs while we = 0 have no effect on state.
- Registers not addressed by rd keep their value.

Test Plan:
1. Reset, then we=1, wb_select=ALU_OUT, rd=1, alu_result=AAAA_AAAA; one edge; we=0, rs1=1 -> read_data1 = AAAA_AAAA.
2. we=1, wb_select=IMM_DAT, rd=2, imm_data=5555_5555; one edge; rs2=2 -> read_data2 = 5555_5555, and x1 still = AAAA_AAAA.
3. we=1, wb_select=MEM_DAT, rd=1, mem_data=CCCC_CCCC; one edge; rs1=1 -> read_data1 = CCCC_CCCC (overwrite).
4. we=1, wb_select=PC_NEXT, rd=4, pc_next=1234_5678; one edge; rs2=4 -> read_data2 = 1234_5678.
5. we=1, wb_select=ALU_OUT, rd=0, alu_result=FFFF_FFFF; one edge; rs1=0 -> read_data1 = 0000_0000.
6. After writing several registers, assert rst_n=0 between clock edges -> all reads return 0 immediately. Also check that we=0 with changing sources leaves contents unchanged.
